// File: rtl/mult_array_pkg.sv
// Shared types for the sequential array multiplier: FSM state encoding and
// the sizing function for the row counter.
package mult_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The row counter must be able to hold WIDTH, the value it reaches after the last fold.
  function automatic int row_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_array_row.sv
// One combinational array row: adds (or subtracts, for the Baugh-Wooley MSB row)
// the shifted, masked multiplicand into the 2*WIDTH-bit partial sum.
module mult_array_row #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic               b_bit_i,
  input  logic [SHW-1:0]     shamt_i,
  input  logic               sign_ext_i,
  input  logic               neg_i,
  input  logic [2*WIDTH-1:0] psum_i,
  output logic [2*WIDTH-1:0] sum_o,
  output logic               cout_o
);

  logic [2*WIDTH-1:0] pp_ext;
  logic [2*WIDTH-1:0] pp_row;
  logic [2*WIDTH-1:0] pp_op;

  assign pp_ext = {{WIDTH{sign_ext_i & a_i[WIDTH-1]}}, a_i};
  assign pp_row = b_bit_i ? (pp_ext << shamt_i) : '0;
  // Subtraction as add of the one's complement plus a carry-in of one.
  assign pp_op  = pp_row ^ {(2*WIDTH){neg_i}};

  assign {cout_o, sum_o} = {1'b0, psum_i} + {1'b0, pp_op} + {{(2*WIDTH){1'b0}}, neg_i};

endmodule

// File: rtl/mult_array_seq.sv
// Sequential WIDTH x WIDTH array multiplier folding ROWS_PER_CYC rows per clock.
// Optional MULT_ARRAY_SIGNED_EN adds signed_mode (two's complement, Baugh-Wooley rows).
//   state   | meaning
//   ST_IDLE | waiting for operands, in_ready high
//   ST_BUSY | folding ROWS_PER_CYC rows into acc per cycle
//   ST_DONE | product on p, out_valid high until taken
module mult_array_seq
  import mult_array_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int ROWS_PER_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
`ifdef MULT_ARRAY_SIGNED_EN
  ,
  input  logic               signed_mode
`endif
);

  localparam int              CW       = row_cnt_width(WIDTH);
  localparam int              PW       = 2 * WIDTH;
  localparam logic [CW-1:0]   LAST_ROW = CW'(WIDTH - ROWS_PER_CYC);
  localparam logic [CW-1:0]   ROW_STEP = CW'(ROWS_PER_CYC);
  localparam logic [CW-1:0]   MSB_ROW  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      p_q, p_d;
  logic [CW-1:0]      row_cnt_q, row_cnt_d;
  logic               sgn_q;
`ifdef MULT_ARRAY_SIGNED_EN
  logic               sgn_d;
`else
  assign sgn_q = 1'b0;
`endif

  logic [ROWS_PER_CYC:0][PW-1:0] psum;
  logic [ROWS_PER_CYC-1:0]       carry_unused;

  assign psum[0] = acc_q;

  for (genvar r = 0; r < ROWS_PER_CYC; r++) begin : g_row
    logic [CW-1:0] row_idx;
    logic          b_bit;

    assign row_idx = row_cnt_q + CW'(r);
    assign b_bit   = |(b_q & (ONE_W << row_idx));

    mult_array_row #(
      .WIDTH (WIDTH),
      .SHW   (CW)
    ) u_row (
      .a_i        (a_q),
      .b_bit_i    (b_bit),
      .shamt_i    (row_idx),
      .sign_ext_i (sgn_q),
      .neg_i      (sgn_q && (row_idx == MSB_ROW)),
      .psum_i     (psum[r]),
      .sum_o      (psum[r+1]),
      .cout_o     (carry_unused[r])
    );
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    row_cnt_d = row_cnt_q;
    p_d       = p_q;
`ifdef MULT_ARRAY_SIGNED_EN
    sgn_d     = sgn_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          acc_d     = '0;
          row_cnt_d = '0;
`ifdef MULT_ARRAY_SIGNED_EN
          sgn_d     = signed_mode;
`endif
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d     = psum[ROWS_PER_CYC];
        row_cnt_d = row_cnt_q + ROW_STEP;
        if (row_cnt_q == LAST_ROW) begin
          p_d     = psum[ROWS_PER_CYC];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      p_q       <= '0;
      row_cnt_q <= '0;
`ifdef MULT_ARRAY_SIGNED_EN
      sgn_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      row_cnt_q <= row_cnt_d;
`ifdef MULT_ARRAY_SIGNED_EN
      sgn_q     <= sgn_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign p         = p_q;

endmodule

// File: tb/tb_mult_array_seq.sv
// Directed bench for mult_array_seq: default 8x8 R=2 instance plus a 16x16 R=4 instance.
module tb_mult_array_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic [15:0] w_a, w_b;
  logic [31:0] w_p;

`ifdef MULT_ARRAY_SIGNED_EN
  logic        signed_mode;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  mult_array_seq #(.WIDTH(8), .ROWS_PER_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
`ifdef MULT_ARRAY_SIGNED_EN
    ,
    .signed_mode (signed_mode)
`endif
  );

  mult_array_seq #(.WIDTH(16), .ROWS_PER_CYC(4)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .a         (w_a),
    .b         (w_b),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .p         (w_p),
    .busy      (w_busy)
`ifdef MULT_ARRAY_SIGNED_EN
    ,
    .signed_mode (signed_mode)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge with the 8-bit DUT idle.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] exp, input int hold);
    int lat;
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    check($sformatf("%s busy", tag), 32'(busy), 32'd1);
    check($sformatf("%s in_ready_low", tag), 32'(in_ready), 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'd4);
    check($sformatf("%s product", tag), 32'(p), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s hold_p", tag), 32'(p), 32'(exp));
      check($sformatf("%s hold_in_ready", tag), 32'(in_ready), 32'd0);
      check($sformatf("%s hold_valid", tag), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("%s valid_dropped", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s in_ready_back", tag), 32'(in_ready), 32'd1);
  endtask

  task automatic run_op16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [31:0] exp);
    int lat;
    w_in_valid = 1'b1;
    w_a        = ta;
    w_b        = tb_v;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    w_a        = 16'($urandom);
    w_b        = 16'($urandom);
    lat = 0;
    while (w_out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'd4);
    check($sformatf("%s product", tag), w_p, exp);
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
    check($sformatf("%s in_ready_back", tag), 32'(w_in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] rwa, rwb;
    int          acc_cyc [4];
    int          w;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    w_in_valid  = 1'b0;
    w_out_ready = 1'b0;
    w_a         = '0;
    w_b         = '0;
`ifdef MULT_ARRAY_SIGNED_EN
    signed_mode = 1'b0;
`endif

    #3;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst p", 32'(p), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst w_p", w_p, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned corners
    run_op("ffxff", 8'hFF, 8'hFF, 16'hFE01, 0);
    run_op("00xa5", 8'h00, 8'hA5, 16'h0000, 0);
    run_op("01x80", 8'h01, 8'h80, 16'h0080, 0);

    // Backpressure for 10 cycles
    run_op("bp", 8'h9A, 8'h37, 16'h2116, 10);

    // Back-to-back: in_valid and out_ready held high
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      ra = 8'(8'h11 * (k + 3));
      rb = 8'(8'h2D + k * 8'h17);
      a  = ra;
      b  = rb;
      @(posedge clk); #1;
      acc_cyc[k] = cyc;
      w = 0;
      while (out_valid !== 1'b1 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      check("b2b product", 32'(p), 32'({8'h00, ra} * {8'h00, rb}));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // Accept-to-accept: N busy cycles, one DONE cycle, one IDLE cycle.
    for (int k = 1; k < 4; k++) check("b2b spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd6);
    check("b2b idle", 32'(in_ready), 32'd1);

    // Random products against the arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op("rand", ra, rb, {8'h00, ra} * {8'h00, rb}, 0);
    end

    // Reset in the second BUSY cycle
    in_valid = 1'b1;
    a        = 8'h55;
    b        = 8'h66;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst p", 32'(p), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("postrst out_valid", 32'(out_valid), 32'd0);
    check("postrst in_ready", 32'(in_ready), 32'd1);
    check("postrst p", 32'(p), 32'd0);
    run_op("0cx0d", 8'h0C, 8'h0D, 16'h009C, 0);

`ifdef MULT_ARRAY_SIGNED_EN
    signed_mode = 1'b1;
    run_op("s ffxff", 8'hFF, 8'hFF, 16'h0001, 0);
    run_op("s 80x7f", 8'h80, 8'h7F, 16'hC080, 0);
    run_op("s 80x80", 8'h80, 8'h80, 16'h4000, 0);
    signed_mode = 1'b0;
    run_op("u ffxff", 8'hFF, 8'hFF, 16'hFE01, 0);
    run_op("u 80x7f", 8'h80, 8'h7F, 16'h3F80, 0);
    run_op("u 80x80", 8'h80, 8'h80, 16'h4000, 0);
`endif

    // 16-bit instance, four rows per cycle
    run_op16("w ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    run_op16("w 8000x0002", 16'h8000, 16'h0002, 32'h0001_0000);
    run_op16("w 0000x1234", 16'h0000, 16'h1234, 32'h0000_0000);
    for (int i = 0; i < 20; i++) begin
      rwa = 16'($urandom);
      rwb = 16'($urandom);
      run_op16("w rand", rwa, rwb, {16'h0000, rwa} * {16'h0000, rwb});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
